reg_arbiter: RTL and testbench

REG_ARBITER -- requirements
Module: reg_arbiter

---
 rtl/reg_arb_pkg.sv | 24 ++
 rtl/reg_arb_rr.sv | 32 +++
 rtl/reg_arbiter.sv | 117 +++++++++++
 tb/tb_reg_arbiter.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/reg_arb_pkg.sv
// Shared types and constants for the three-port register-file arbiter.
// Holds the FSM encoding, requester port indices and the CPU write-protect map.
package reg_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int NUM_PORTS = 3;
   localparam int PORT_CPU  = 0;
   localparam int PORT_CMD  = 1;
   localparam int PORT_DAT  = 2;

   // Addresses the CPU port may read but never write.
   function automatic logic is_read_only(input logic [31:0] a);
      return ((a >= 32'd4)  && (a <= 32'd7))  ||
             (a == 32'd9)                      ||
             ((a >= 32'd16) && (a <= 32'd19));
   endfunction

endpackage

// File: rtl/reg_arb_rr.sv
// Three-way round-robin picker: the search starts at the port after the
// last one granted, and the result is a one-hot grant (all zero when idle).
module reg_arb_rr
   import reg_arb_pkg::*;
(
   input  logic [2:0] i_req,
   input  logic [2:0] i_last,
   output logic [2:0] o_gnt
);

   always_comb begin
      o_gnt = 3'b000;
      case (i_last)
         3'b001: begin
            if      (i_req[PORT_CMD]) o_gnt = 3'b010;
            else if (i_req[PORT_DAT]) o_gnt = 3'b100;
            else if (i_req[PORT_CPU]) o_gnt = 3'b001;
         end
         3'b010: begin
            if      (i_req[PORT_DAT]) o_gnt = 3'b100;
            else if (i_req[PORT_CPU]) o_gnt = 3'b001;
            else if (i_req[PORT_CMD]) o_gnt = 3'b010;
         end
         default: begin
            if      (i_req[PORT_CPU]) o_gnt = 3'b001;
            else if (i_req[PORT_CMD]) o_gnt = 3'b010;
            else if (i_req[PORT_DAT]) o_gnt = 3'b100;
         end
      endcase
   end

endmodule

// File: rtl/reg_arbiter.sv
// Arbitrates CPU, command-engine and data-engine accesses onto a single
// register-file port, one transaction at a time, with a WAIT timeout.
module reg_arbiter
   import reg_arb_pkg::*;
#(
   parameter int data_width     = 32,
   parameter int addr_width     = 5,
   parameter int timeout_cycles = 15
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic [2:0]                       req,
   input  logic [2:0]                       rw,
   input  logic [2:0][addr_width-1:0]       addr,
   input  logic [2:0][data_width-1:0]       wdata,
   output logic [2:0]                       ack,
   output logic [2:0]                       err,
   output logic [data_width-1:0]            rdata,
   output logic                             reg_req,
   output logic                             reg_rw,
   output logic [addr_width-1:0]            reg_addr,
   output logic [data_width-1:0]            reg_wdata,
   input  logic                             reg_ack,
   input  logic [data_width-1:0]            reg_rdata
);

   localparam int CW = $clog2(timeout_cycles + 1);

   state_t          r_state;
   logic [2:0]      r_last;
   logic [CW-1:0]   r_cnt;

   logic [2:0]      w_gnt;
   logic [1:0]      w_idx;
   logic            w_ro_block;
   logic            w_timeout;

   reg_arb_rr u_rr (
      .i_req  (req),
      .i_last (r_last),
      .o_gnt  (w_gnt)
   );

   always_comb begin
      w_idx = 2'd0;
      if (w_gnt[PORT_CMD]) w_idx = 2'd1;
      if (w_gnt[PORT_DAT]) w_idx = 2'd2;
   end

   assign w_ro_block = w_gnt[PORT_CPU] && !rw[PORT_CPU] &&
                       is_read_only(32'(addr[PORT_CPU]));
   assign w_timeout  = (r_cnt >= CW'(timeout_cycles - 1));

   // r_last doubles as the winner's one-hot ack mask; resetting it to port 2
   // makes the first search after reset begin at port 0.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= ST_IDLE;
         r_last    <= 3'b100;
         r_cnt     <= '0;
         ack       <= '0;
         err       <= '0;
         rdata     <= '0;
         reg_req   <= 1'b0;
         reg_rw    <= 1'b0;
         reg_addr  <= '0;
         reg_wdata <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (|req) begin
                  r_last    <= w_gnt;
                  reg_rw    <= rw[w_idx];
                  reg_addr  <= addr[w_idx];
                  reg_wdata <= wdata[w_idx];
                  if (w_ro_block) begin
                     ack     <= w_gnt;
                     err     <= w_gnt;
                     rdata   <= '0;
                     r_state <= ST_DONE;
                  end else begin
                     reg_req <= 1'b1;
                     r_state <= ST_ISSUE;
                  end
               end
            end
            ST_ISSUE: begin
               reg_req <= 1'b0;
               r_cnt   <= '0;
               r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (reg_ack) begin
                  ack     <= r_last;
                  err     <= '0;
                  rdata   <= reg_rw ? reg_rdata : '0;
                  r_state <= ST_DONE;
               end else if (w_timeout) begin
                  ack     <= r_last;
                  err     <= r_last;
                  rdata   <= '0;
                  r_state <= ST_DONE;
               end else if (r_cnt != CW'(timeout_cycles)) begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               ack     <= '0;
               err     <= '0;
               rdata   <= '0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reg_arbiter.sv
// Directed bench for reg_arbiter with a simple one-cycle register-file responder.
module tb_reg_arbiter;

   logic              clk;
   logic              reset_n;
   logic [2:0]        req;
   logic [2:0]        rw;
   logic [2:0][4:0]   addr;
   logic [2:0][31:0]  wdata;
   logic [2:0]        ack;
   logic [2:0]        err;
   logic [31:0]       rdata;
   logic              reg_req;
   logic              reg_rw;
   logic [4:0]        reg_addr;
   logic [31:0]       reg_wdata;
   logic              reg_ack;
   logic [31:0]       reg_rdata;

   int                n_total = 0;
   int                n_bad   = 0;
   int                n_issue = 0;
   logic              ack_en  = 1'b1;
   logic [31:0]       mem [32];

   reg_arbiter #(
      .data_width     (32),
      .addr_width     (5),
      .timeout_cycles (15)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req       (req),
      .rw        (rw),
      .addr      (addr),
      .wdata     (wdata),
      .ack       (ack),
      .err       (err),
      .rdata     (rdata),
      .reg_req   (reg_req),
      .reg_rw    (reg_rw),
      .reg_addr  (reg_addr),
      .reg_wdata (reg_wdata),
      .reg_ack   (reg_ack),
      .reg_rdata (reg_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Register file: answers an issued command in the following cycle.
   initial begin
      logic       v;
      logic       r;
      logic [4:0] a;
      logic [31:0] d;
      for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 + i;
      reg_ack   = 1'b0;
      reg_rdata = '0;
      forever begin
         @(posedge clk);
         v = reg_req; r = reg_rw; a = reg_addr; d = reg_wdata;
         #1;
         if (v) n_issue++;
         if (v && ack_en && !r) mem[a] = d;
         reg_ack   = v && ack_en;
         reg_rdata = (v && ack_en && r) ? mem[a] : 32'h0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic txn(input int p, input logic r, input logic [4:0] a, input logic [31:0] d,
                      input int exp_lat, input logic exp_err, input logic [31:0] exp_rd,
                      input int exp_iss, input string tag);
      int n;
      int i0;
      i0 = n_issue;
      rw[p] = r; addr[p] = a; wdata[p] = d; req[p] = 1'b1;
      n = 0;
      do begin
         step();
         n++;
      end while (ack == 3'b000 && n < 60);
      chk({tag, "_lat"}, n, exp_lat);
      chk({tag, "_ack"}, {29'd0, ack}, 32'(1 << p));
      chk({tag, "_err"}, {31'd0, err[p]}, {31'd0, exp_err});
      chk({tag, "_rd"}, rdata, exp_rd);
      chk({tag, "_iss"}, n_issue - i0, exp_iss);
      req[p] = 1'b0;
      step();
      chk({tag, "_ack1"}, {29'd0, ack}, 32'd0);
   endtask

   initial begin
      int          ro_a   [8] = '{3, 4, 7, 8, 9, 16, 19, 20};
      logic        ro_e   [8] = '{0, 1, 1, 0, 1, 1, 1, 0};
      int          order  [6] = '{0, 1, 2, 0, 1, 2};
      logic [31:0] exp_rd [3] = '{32'hDEAD_BEEF, 32'h1234_5678, 32'hA000_000A};
      int          n;

      reset_n = 1'b1; req = '0; rw = '0; addr = '0; wdata = '0;
      #2 reset_n = 1'b0;
      step(); step();
      chk("rst_ack", {29'd0, ack}, 32'd0);
      chk("rst_err", {29'd0, err}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_regreq", {31'd0, reg_req}, 32'd0);
      chk("rst_regaddr", {27'd0, reg_addr}, 32'd0);
      chk("rst_regwdata", reg_wdata, 32'd0);
      reset_n = 1'b1;
      step();

      txn(0, 1'b0, 5'd2, 32'hDEAD_BEEF, 3, 1'b0, 32'h0, 1, "wr2");
      txn(0, 1'b1, 5'd2, 32'h0, 3, 1'b0, 32'hDEAD_BEEF, 1, "rd2");
      txn(0, 1'b0, 5'd9, 32'h1234_5678, 1, 1'b1, 32'h0, 0, "cpu_wr9");
      txn(1, 1'b0, 5'd9, 32'h1234_5678, 3, 1'b0, 32'h0, 1, "cmd_wr9");
      txn(2, 1'b1, 5'd9, 32'h0, 3, 1'b0, 32'h1234_5678, 1, "dat_rd9");
      txn(0, 1'b1, 5'd4, 32'h0, 3, 1'b0, 32'hA000_0004, 1, "cpu_rd4");
      for (int i = 0; i < 8; i++)
         txn(0, 1'b0, 5'(ro_a[i]), 32'h1111_0000 + ro_a[i], ro_e[i] ? 1 : 3, ro_e[i],
             32'h0, ro_e[i] ? 0 : 1, $sformatf("ro_%0d", ro_a[i]));

      ack_en = 1'b0;
      txn(1, 1'b1, 5'd5, 32'h0, 17, 1'b1, 32'h0, 1, "tmo");
      ack_en = 1'b1;
      txn(0, 1'b1, 5'd2, 32'h0, 3, 1'b0, 32'hDEAD_BEEF, 1, "post_tmo");

      // Park a CPU read in WAIT, then reset underneath it.
      ack_en = 1'b0;
      rw[0] = 1'b1; addr[0] = 5'd2; req[0] = 1'b1;
      step(); step(); step();
      reset_n = 1'b0;
      req = '0;
      #1;
      chk("mid_rst_ack", {29'd0, ack}, 32'd0);
      chk("mid_rst_regaddr", {27'd0, reg_addr}, 32'd0);
      chk("mid_rst_regrw", {31'd0, reg_rw}, 32'd0);
      n = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (ack != 3'b000) n++;
      end
      chk("mid_rst_noack", n, 0);
      reset_n = 1'b1;
      ack_en  = 1'b1;

      rw = 3'b111;
      addr[0] = 5'd2; addr[1] = 5'd9; addr[2] = 5'd10;
      req = 3'b111;
      for (int k = 0; k < 6; k++) begin
         n = 0;
         do begin
            step();
            n++;
         end while (ack == 3'b000 && n < 30);
         chk($sformatf("rr_gap%0d", k), n, (k == 0) ? 3 : 4);
         chk($sformatf("rr_ack%0d", k), {29'd0, ack}, 32'(1 << order[k]));
         chk($sformatf("rr_rd%0d", k), rdata, exp_rd[order[k]]);
      end
      req = '0;
      step(); step();
      chk("end_idle_regreq", {31'd0, reg_req}, 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
